// File: rtl/pipeline_pkg.sv
// -----------------------------------------------------------------------------
// pipeline_pkg
// Shared types and helpers for the data-memory responder.
//   DATA_WIDTH / RAM_SIZE : default bus width and byte-address width
//   load_funct3_e / store_funct3_e : RV64 load/store size+sign encodings
//   rsp_state_e           : responder handshake FSM states
//   size_mask()           : low address bits covered by an access size
//   illegal_op()          : reserved / unsupported funct3 detection
//   misaligned()          : address not a multiple of the access size
// Optional build macro DMEM_MISALIGN_CHECK_EN is consumed by dmem_responder.
// -----------------------------------------------------------------------------
package pipeline_pkg;

  localparam int DATA_WIDTH = 64;
  localparam int RAM_SIZE   = 12;

  typedef enum logic [2:0] {
    LB  = 3'b000,
    LH  = 3'b001,
    LW  = 3'b010,
    LD  = 3'b011,
    LBU = 3'b100,
    LHU = 3'b101,
    LWU = 3'b110
  } load_funct3_e;

  typedef enum logic [2:0] {
    SB = 3'b000,
    SH = 3'b001,
    SW = 3'b010,
    SD = 3'b011
  } store_funct3_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } rsp_state_e;

  localparam logic [2:0] F3_RESERVED = 3'b111;

  // Address bits that lie inside an access of 1/2/4/8 bytes.
  function automatic logic [2:0] size_mask(input logic [1:0] size);
    case (size)
      2'd0:    return 3'b000;
      2'd1:    return 3'b001;
      2'd2:    return 3'b011;
      default: return 3'b111;
    endcase
  endfunction

  // Reserved encoding, or a store asking for one of the load-only
  // zero-extending encodings.
  function automatic logic illegal_op(input logic we, input logic [2:0] funct3);
    return (funct3 == F3_RESERVED) || (we && funct3[2]);
  endfunction

  function automatic logic misaligned(input logic [1:0] size, input logic [2:0] addr_lo);
    return |(addr_lo & size_mask(size));
  endfunction

endpackage

// File: rtl/dmem_lane_fmt.sv
// -----------------------------------------------------------------------------
// dmem_lane_fmt
// Purely combinational byte-lane formatting for a 64-bit little-endian word.
// Store side: byte-enable mask and lane-aligned write data.
// Load side : extract the addressed bytes and sign/zero extend.
// Address bits below the access size are ignored (rounded down).
// Ports:
//   st_size_i    in  2   store size (funct3[1:0])
//   st_addr_lo_i in  3   store byte offset in word
//   st_wdata_i   in  64  store data, LSB-aligned
//   st_be_o      out 8   per-byte write enable
//   st_wdata_o   out 64  store data shifted into its lanes
//   ld_funct3_i  in  3   load funct3 (size + sign)
//   ld_addr_lo_i in  3   load byte offset in word
//   ld_word_i    in  64  raw word read from storage
//   ld_data_o    out 64  extended load result (0 for reserved funct3)
// -----------------------------------------------------------------------------
module dmem_lane_fmt
  import pipeline_pkg::*;
(
  input  logic [1:0]  st_size_i,
  input  logic [2:0]  st_addr_lo_i,
  input  logic [63:0] st_wdata_i,
  output logic [7:0]  st_be_o,
  output logic [63:0] st_wdata_o,
  input  logic [2:0]  ld_funct3_i,
  input  logic [2:0]  ld_addr_lo_i,
  input  logic [63:0] ld_word_i,
  output logic [63:0] ld_data_o
);

  logic [2:0]  st_off;
  logic [7:0]  st_be_base;
  logic [2:0]  ld_off;
  logic [63:0] ld_shifted;

  always_comb begin
    st_off = st_addr_lo_i & ~size_mask(st_size_i);
    case (st_size_i)
      2'd0:    st_be_base = 8'h01;
      2'd1:    st_be_base = 8'h03;
      2'd2:    st_be_base = 8'h0F;
      default: st_be_base = 8'hFF;
    endcase
    st_be_o    = st_be_base << st_off;
    st_wdata_o = st_wdata_i << {st_off, 3'b000};
  end

  always_comb begin
    ld_off     = ld_addr_lo_i & ~size_mask(ld_funct3_i[1:0]);
    // Bring the addressed bytes down to bit 0, then extend.
    ld_shifted = ld_word_i >> {ld_off, 3'b000};
    case (ld_funct3_i)
      LB:      ld_data_o = {{56{ld_shifted[7]}},  ld_shifted[7:0]};
      LH:      ld_data_o = {{48{ld_shifted[15]}}, ld_shifted[15:0]};
      LW:      ld_data_o = {{32{ld_shifted[31]}}, ld_shifted[31:0]};
      LD:      ld_data_o = ld_shifted;
      LBU:     ld_data_o = {56'd0, ld_shifted[7:0]};
      LHU:     ld_data_o = {48'd0, ld_shifted[15:0]};
      LWU:     ld_data_o = {32'd0, ld_shifted[31:0]};
      default: ld_data_o = '0;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
// Single-outstanding data-memory responder with valid/ready request and
// response channels, a programmable wait of LATENCY cycles, and byte-lane
// RV64 loads/stores into 2^(RAM_SIZE-3) 64-bit words of inferred RAM.
// Optional macro DMEM_MISALIGN_CHECK_EN: misaligned accesses fault instead of
// being rounded down.
// Ports:
//   clk_i        in  1           clock, rising edge
//   rst_i        in  1           synchronous active-high reset (RAM kept)
//   req_valid_i  in  1           request present
//   req_ready_o  out 1           high only when idle
//   req_we_i     in  1           1 = store, 0 = load
//   req_addr_i   in  RAM_SIZE    byte address
//   req_wdata_i  in  DATA_WIDTH  store data, LSB-aligned
//   req_funct3_i in  3           RV64 load/store funct3
//   rsp_valid_o  out 1           response present
//   rsp_ready_i  in  1           response consumed
//   rsp_rdata_o  out DATA_WIDTH  load result (0 for stores/faults)
//   rsp_err_o    out 1           request faulted
// -----------------------------------------------------------------------------
module dmem_responder #(
  parameter int DATA_WIDTH = pipeline_pkg::DATA_WIDTH,
  parameter int RAM_SIZE   = pipeline_pkg::RAM_SIZE,
  parameter int LATENCY    = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic [RAM_SIZE-1:0]   req_addr_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  input  logic [2:0]            req_funct3_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [DATA_WIDTH-1:0] rsp_rdata_o,
  output logic                  rsp_err_o
);

  import pipeline_pkg::*;

  localparam int         IDX_W    = RAM_SIZE - 3;
  localparam int         WORDS    = 1 << IDX_W;
  localparam logic [3:0] LAT_INIT = 4'(LATENCY);
  localparam bit         LAT_ZERO = (LATENCY == 0);

  rsp_state_e          state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;

  logic                we_q;
  logic [RAM_SIZE-1:0] addr_q;
  logic [63:0]         wdata_q;
  logic [2:0]          funct3_q;

  logic                accept;
  logic                access_go;
  logic                op_we;
  logic [RAM_SIZE-1:0] op_addr;
  logic [63:0]         op_wdata;
  logic [2:0]          op_funct3;
  logic [IDX_W-1:0]    op_idx;
  logic                op_err;
  logic                rsp_err;
  logic                wr_en;
  logic                rd_en;

  logic [7:0]          st_be;
  logic [63:0]         st_wdata;
  logic [63:0]         rd_word;
  logic [63:0]         ld_data;

  assign accept = req_valid_i && (state_q == ST_IDLE);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid_i) begin
          cnt_d   = LAT_INIT;
          state_d = LAT_ZERO ? ST_RESP : ST_WAIT;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        // <= 1 rather than == 1 so a corrupted count can never trap the FSM.
        if (cnt_q <= 4'd1) begin
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready_i) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs. Response fields are forced to zero outside RESP so reset
  // and idle present a clean bus without resetting the RAM read register.
  // ---------------------------------------------------------------------------
  always_comb begin
    req_ready_o = (state_q == ST_IDLE);
    rsp_valid_o = (state_q == ST_RESP);
    rsp_err_o   = 1'b0;
    rsp_rdata_o = '0;
    if (state_q == ST_RESP) begin
      rsp_err_o = rsp_err;
      if (!rsp_err && !we_q) begin
        rsp_rdata_o = DATA_WIDTH'(ld_data);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Request capture
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      funct3_q <= '0;
    end else if (accept) begin
      we_q     <= req_we_i;
      addr_q   <= req_addr_i;
      wdata_q  <= 64'(req_wdata_i);
      funct3_q <= req_funct3_i;
    end
  end

  // ---------------------------------------------------------------------------
  // Access operands. With zero latency the access happens on the accept edge,
  // so the live request is used; otherwise the captured copy is used.
  // ---------------------------------------------------------------------------
  always_comb begin
    if (state_q == ST_IDLE) begin
      op_we     = req_we_i;
      op_addr   = req_addr_i;
      op_wdata  = 64'(req_wdata_i);
      op_funct3 = req_funct3_i;
    end else begin
      op_we     = we_q;
      op_addr   = addr_q;
      op_wdata  = wdata_q;
      op_funct3 = funct3_q;
    end
    op_idx = op_addr[RAM_SIZE-1:3];

    if (LAT_ZERO) begin
      access_go = accept;
    end else begin
      access_go = (state_q == ST_WAIT) && (cnt_q == 4'd1);
    end

    op_err  = illegal_op(op_we, op_funct3);
    rsp_err = illegal_op(we_q, funct3_q);
`ifdef DMEM_MISALIGN_CHECK_EN
    op_err  = op_err  | misaligned(op_funct3[1:0], op_addr[2:0]);
    rsp_err = rsp_err | misaligned(funct3_q[1:0], addr_q[2:0]);
`endif

    // Reset on the access edge cancels the access entirely.
    wr_en = access_go && op_we && !op_err && !rst_i;
    rd_en = access_go && !op_we && !rst_i;
  end

  dmem_lane_fmt u_lane_fmt (
    .st_size_i    (op_funct3[1:0]),
    .st_addr_lo_i (op_addr[2:0]),
    .st_wdata_i   (op_wdata),
    .st_be_o      (st_be),
    .st_wdata_o   (st_wdata),
    .ld_funct3_i  (funct3_q),
    .ld_addr_lo_i (addr_q[2:0]),
    .ld_word_i    (rd_word),
    .ld_data_o    (ld_data)
  );

  // ---------------------------------------------------------------------------
  // Storage: one byte-wide RAM per lane so each lane is an independent
  // simple-dual-use block with registered read. Not cleared by reset.
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_lane
      logic [7:0] lane_mem [WORDS];
      logic [7:0] lane_rd_q;

      always_ff @(posedge clk_i) begin
        if (wr_en && st_be[gi]) begin
          lane_mem[op_idx] <= st_wdata[gi*8 +: 8];
        end
        if (rd_en) begin
          lane_rd_q <= lane_mem[op_idx];
        end
      end

      assign rd_word[gi*8 +: 8] = lane_rd_q;
    end
  endgenerate

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

  localparam int LAT = 3;
`ifdef DMEM_MISALIGN_CHECK_EN
  localparam bit MIS_EN = 1'b1;
`else
  localparam bit MIS_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [11:0] req_addr;
  logic [63:0] req_wdata;
  logic [2:0]  req_funct3;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [63:0] rsp_rdata;
  logic        rsp_err;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference memory: plain byte array, little-endian.
  logic [7:0] mem_m [4096];

  dmem_responder #(
    .DATA_WIDTH (64),
    .RAM_SIZE   (12),
    .LATENCY    (LAT)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_we_i     (req_we),
    .req_addr_i   (req_addr),
    .req_wdata_i  (req_wdata),
    .req_funct3_i (req_funct3),
    .rsp_valid_o  (rsp_valid),
    .rsp_ready_i  (rsp_ready),
    .rsp_rdata_o  (rsp_rdata),
    .rsp_err_o    (rsp_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic bit model_err(bit we, int addr, int f3);
    int size;
    size = 1 << (f3 % 4);
    if (f3 == 7) return 1'b1;
    if (we && f3 >= 4) return 1'b1;
    if (MIS_EN && (addr % size) != 0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [63:0] model_load(int addr, int f3);
    int size;
    int base;
    logic [63:0] v;
    size = 1 << (f3 % 4);
    base = addr - (addr % size);
    v = '0;
    for (int i = 0; i < size; i++) v[8*i +: 8] = mem_m[base + i];
    if (f3 < 4 && v[8*size-1] == 1'b1)
      for (int i = 8*size; i < 64; i++) v[i] = 1'b1;
    return v;
  endfunction

  task automatic model_store(int addr, int f3, logic [63:0] wdata);
    int size;
    int base;
    size = 1 << (f3 % 4);
    base = addr - (addr % size);
    for (int i = 0; i < size; i++) mem_m[base + i] = wdata[8*i +: 8];
  endtask

  // Predict response; update model when a store takes effect.
  task automatic model_txn(bit we, int addr, int f3, logic [63:0] wdata,
                           output logic [63:0] exp_rd, output logic exp_err);
    exp_err = model_err(we, addr, f3);
    exp_rd  = (exp_err || we) ? 64'd0 : model_load(addr, f3);
    if (we && !exp_err) model_store(addr, f3, wdata);
  endtask

  // ---------------- transaction driver ----------------
  // Returns the first response, the accept-to-valid latency (999 on timeout)
  // and whether outputs stayed stable while rsp_ready was held low.
  task automatic txn(input bit we, input logic [11:0] addr, input logic [63:0] wdata,
                     input logic [2:0] f3, input int hold,
                     output logic [63:0] rdata, output logic err,
                     output int lat, output bit stable);
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_funct3 = f3;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    @(negedge clk);
    while (!rsp_valid && lat < 64) begin
      @(negedge clk);
      lat++;
    end
    stable = 1'b1;
    if (!rsp_valid) begin
      lat = 999;
      rdata = 'x;
      err = 1'bx;
      stable = 1'b0;
    end else begin
      rdata = rsp_rdata;
      err = rsp_err;
      for (int i = 0; i < hold; i++) begin
        // Conflicting request while busy: must be ignored.
        req_valid = 1'b1; req_we = 1'b1; req_addr = addr; req_wdata = ~wdata; req_funct3 = 3'b011;
        @(negedge clk);
        if (rsp_valid !== 1'b1 || rsp_rdata !== rdata || rsp_err !== err || req_ready !== 1'b0)
          stable = 1'b0;
      end
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) stable = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
    req_we = 1'b0; req_addr = '0; req_wdata = '0; req_funct3 = '0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_rdata !== 64'd0 || rsp_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got ready=%b valid=%b rdata=%h err=%b want 1 0 0 0",
               req_ready, rsp_valid, rsp_rdata, rsp_err);
    end
    rst = 1'b0;
    $display("test_reset: ready=%b valid=%b", req_ready, rsp_valid);
  endtask

  task automatic init_region();
    logic [63:0] rd, erd, w;
    logic er, eer;
    int lat;
    bit st;
    for (int wi = 0; wi < 32; wi++) begin
      w = {$urandom, $urandom};
      model_txn(1'b1, wi*8, 3, w, erd, eer);
      txn(1'b1, 12'(wi*8), w, 3'b011, 0, rd, er, lat, st);
      n_checks++;
      if (er !== eer) begin
        n_fail++;
        $display("FAIL init_sd addr=%h: err got %b want %b", wi*8, er, eer);
      end
    end
  endtask

  typedef struct {
    bit          we;
    logic [11:0] addr;
    logic [63:0] wdata;
    logic [2:0]  f3;
    logic [63:0] exp_rd;
    bit          exp_err;
  } dir_t;

  task automatic test_directed();
    dir_t v [12];
    logic [63:0] rd, mrd;
    logic er, mer;
    int lat;
    bit st;
    v[0]  = '{1'b1, 12'h010, 64'h8877665544332211, 3'b011, 64'h0, 1'b0};
    v[1]  = '{1'b0, 12'h010, 64'h0, 3'b011, 64'h8877665544332211, 1'b0};
    v[2]  = '{1'b0, 12'h017, 64'h0, 3'b000, 64'hFFFFFFFFFFFFFF88, 1'b0};
    v[3]  = '{1'b0, 12'h017, 64'h0, 3'b100, 64'h0000000000000088, 1'b0};
    v[4]  = '{1'b1, 12'h012, 64'h000000000000BEEF, 3'b001, 64'h0, 1'b0};
    v[5]  = '{1'b0, 12'h010, 64'h0, 3'b011, 64'h88776655BEEF2211, 1'b0};
    v[6]  = '{1'b0, 12'h012, 64'h0, 3'b001, 64'hFFFFFFFFFFFFBEEF, 1'b0};
    v[7]  = '{1'b0, 12'h012, 64'h0, 3'b010,
              MIS_EN ? 64'h0 : 64'hFFFFFFFFBEEF2211, MIS_EN};
    v[8]  = '{1'b0, 12'h010, 64'h0, 3'b111, 64'h0, 1'b1};
    v[9]  = '{1'b1, 12'h010, 64'hDEADBEEFDEADBEEF, 3'b100, 64'h0, 1'b1};
    v[10] = '{1'b1, 12'h010, 64'h0123456789ABCDEF, 3'b111, 64'h0, 1'b1};
    v[11] = '{1'b0, 12'h010, 64'h0, 3'b011, 64'h88776655BEEF2211, 1'b0};
    for (int i = 0; i < 12; i++) begin
      model_txn(v[i].we, int'(v[i].addr), int'(v[i].f3), v[i].wdata, mrd, mer);
      txn(v[i].we, v[i].addr, v[i].wdata, v[i].f3, 0, rd, er, lat, st);
      $display("directed %0d: we=%b addr=%h f3=%0d rdata=%h err=%b", i, v[i].we, v[i].addr, v[i].f3, rd, er);
      n_checks++;
      if (rd !== v[i].exp_rd) begin
        n_fail++;
        $display("FAIL directed_rdata[%0d]: got %h want %h", i, rd, v[i].exp_rd);
      end
      n_checks++;
      if (er !== v[i].exp_err) begin
        n_fail++;
        $display("FAIL directed_err[%0d]: got %b want %b", i, er, v[i].exp_err);
      end
    end
  endtask

  task automatic test_latency();
    logic [63:0] rd, erd;
    logic er, eer;
    int lat;
    bit st;
    model_txn(1'b0, 'h010, 3, 64'h0, erd, eer);
    txn(1'b0, 12'h010, 64'h0, 3'b011, 5, rd, er, lat, st);
    $display("test_latency: lat=%0d stable=%b rdata=%h", lat, st, rd);
    n_checks++;
    if (lat !== LAT + 1) begin
      n_fail++;
      $display("FAIL latency: got %0d cycles want %0d", lat, LAT + 1);
    end
    n_checks++;
    if (st !== 1'b1) begin
      n_fail++;
      $display("FAIL hold_stable: got stable=%b want 1", st);
    end
    n_checks++;
    if (rd !== erd || er !== eer) begin
      n_fail++;
      $display("FAIL latency_data: got %h/%b want %h/%b", rd, er, erd, eer);
    end
  endtask

  task automatic test_reset_in_wait();
    logic [63:0] rd, erd;
    logic er, eer;
    int lat;
    bit st;
    bit quiet;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 12'h020; req_wdata = 64'h1; req_funct3 = 3'b011;
    @(posedge clk); #1;
    req_valid = 1'b0;
    // Last wait cycle: the following edge would perform the write.
    repeat (LAT) @(negedge clk);
    n_checks++;
    if (rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL wait_no_valid: got %b want 0", rsp_valid);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_rdata !== 64'd0 || rsp_err !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_in_wait: got ready=%b valid=%b rdata=%h err=%b want 1 0 0 0",
               req_ready, rsp_valid, rsp_rdata, rsp_err);
    end
    quiet = 1'b1;
    repeat (LAT + 2) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0) quiet = 1'b0;
    end
    n_checks++;
    if (quiet !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_in_wait_quiet: got rsp_valid activity want none");
    end
    model_txn(1'b0, 'h020, 3, 64'h0, erd, eer);
    txn(1'b0, 12'h020, 64'h0, 3'b011, 0, rd, er, lat, st);
    $display("test_reset_in_wait: LD 0x020 rdata=%h", rd);
    n_checks++;
    if (rd !== erd || er !== eer) begin
      n_fail++;
      $display("FAIL rst_in_wait_mem: got %h/%b want %h/%b", rd, er, erd, eer);
    end
  endtask

  task automatic test_reset_in_resp();
    int n;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 12'h018; req_wdata = 64'h0; req_funct3 = 3'b011;
    @(posedge clk); #1;
    req_valid = 1'b0;
    n = 0;
    @(negedge clk);
    while (!rsp_valid && n < 64) begin
      @(negedge clk);
      n++;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || rsp_rdata !== 64'd0) begin
      n_fail++;
      $display("FAIL rst_in_resp: got valid=%b ready=%b rdata=%h want 0 1 0", rsp_valid, req_ready, rsp_rdata);
    end
    $display("test_reset_in_resp: valid=%b ready=%b", rsp_valid, req_ready);
  endtask

  task automatic test_random();
    logic [63:0] rd, erd, w;
    logic er, eer;
    int lat, addr, f3;
    bit we, st;
    for (int i = 0; i < 250; i++) begin
      we   = 1'($urandom_range(0, 1));
      addr = int'($urandom_range(0, 255));
      f3   = int'($urandom_range(0, 7));
      w    = {$urandom, $urandom};
      model_txn(we, addr, f3, w, erd, eer);
      txn(we, 12'(addr), w, 3'(f3), int'($urandom_range(0, 2)), rd, er, lat, st);
      $display("random %0d: we=%b addr=%h f3=%0d rdata=%h err=%b lat=%0d", i, we, addr, f3, rd, er, lat);
      n_checks++;
      if (rd !== erd || er !== eer) begin
        n_fail++;
        $display("FAIL random[%0d]: got %h/%b want %h/%b", i, rd, er, erd, eer);
      end
      n_checks++;
      if (lat !== LAT + 1 || st !== 1'b1) begin
        n_fail++;
        $display("FAIL random_timing[%0d]: got lat=%0d stable=%b want %0d 1", i, lat, st, LAT + 1);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] rd, erd, w;
    logic er, eer;
    int lat, addr, f3;
    bit st;
    for (int i = 0; i < 16; i++) begin
      f3   = int'($urandom_range(0, 3));
      addr = int'($urandom_range(0, 255));
      addr = addr - (addr % (1 << f3));
      w    = {$urandom, $urandom};
      model_txn(1'b1, addr, f3, w, erd, eer);
      txn(1'b1, 12'(addr), w, 3'(f3), 0, rd, er, lat, st);
      model_txn(1'b0, addr, f3, 64'h0, erd, eer);
      txn(1'b0, 12'(addr), 64'h0, 3'(f3), 0, rd, er, lat, st);
      $display("b2b %0d: addr=%h f3=%0d wdata=%h rdata=%h", i, addr, f3, w, rd);
      n_checks++;
      if (rd !== erd || er !== eer) begin
        n_fail++;
        $display("FAIL back_to_back[%0d]: got %h/%b want %h/%b", i, rd, er, erd, eer);
      end
    end
  endtask

  initial begin
    test_reset();
    init_region();
    test_directed();
    test_latency();
    test_reset_in_wait();
    test_reset_in_resp();
    test_random();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, data bus width in bits.
REQ-002 SHALL have parameter RAM_SIZE, default 12, byte-address width; storage is 2^(RAM_SIZE-3) 64-bit words.
REQ-003 SHALL have parameter LATENCY, default 1, wait cycles between accept and access (legal range 0..15).
REQ-004 SHALL have ports:
- clk_i  in  1  sole clock, rising edge.
- rst_i  in  1  reset; synchronous, active-high.
- req_valid_i  in  1  request present.
- req_ready_o  out  1  responder can accept.
- req_we_i  in  1  1=store, 0=load.
- req_addr_i  in  RAM_SIZE  byte address.
- req_wdata_i  in  DATA_WIDTH  store data, LSB-aligned.
- req_funct3_i  in  3  RV64 load/store funct3 (size/sign).
- rsp_valid_o  out  1  response present.
- rsp_ready_i  in  1  core accepts response.
- rsp_rdata_o  out  DATA_WIDTH  load result, extended.
- rsp_err_o  out  1  request faulted.

Function
REQ-005 SHALL implement FSM IDLE, WAIT, RESP; req_ready_o=1 only in IDLE; rsp_valid_o=1 only in RESP.
REQ-006 On req_valid_i&req_ready_o SHALL latch we/addr/wdata/funct3, load counter with LATENCY, go WAIT (LATENCY>0) or RESP (LATENCY=0).
REQ-007 In WAIT SHALL decrement counter; at counter=1 SHALL perform access and go RESP.
REQ-008 Access SHALL occur on the edge entering RESP; accept-to-rsp_valid latency SHALL be LATENCY+1 cycles.
REQ-009 Loads SHALL be little-endian, extracting bytes at addr[2:0]; funct3 000/001/010/011 sign-extend, 100/101/110 zero-extend.
REQ-010 Stores SHALL write only byte lanes for funct3 000/001/010/011 (1/2/4/8 bytes) at addr[2:0]; other lanes unchanged.
REQ-011 Store responses SHALL return rsp_rdata_o=0.
REQ-012 funct3=111, or store with funct3[2]=1, SHALL respond rsp_err_o=1, rsp_rdata_o=0, no memory change.
REQ-013 RESP SHALL hold rsp_valid_o, rsp_rdata_o, rsp_err_o stable until rsp_ready_i=1, then go IDLE; next accept no earlier than following cycle.
REQ-014 Requests while not IDLE SHALL be ignored (no queueing).
REQ-015 Load immediately after store to same address SHALL return stored data.

Reset
REQ-016 rst_i SHALL force IDLE, counter 0, req_ready_o=1, rsp_valid_o=0, rsp_rdata_o=0, rsp_err_o=0 at next edge.
REQ-017 rst_i asserted in WAIT SHALL abort without writing; asserted in RESP SHALL drop response. Memory contents SHALL NOT be cleared by reset.

Configuration
REQ-018 Macro DMEM_MISALIGN_CHECK_EN defined: addr not multiple of access size SHALL give rsp_err_o=1, rsp_rdata_o=0, no write.
REQ-019 Macro undefined: address bits below access size SHALL be ignored (rounded down); rsp_err_o set only per REQ-012.

Structure
REQ-020 pipeline_pkg SHALL hold funct3 width enum (LB..LWU, SB..SD) and responder state enum; DATA_WIDTH/RAM_SIZE SHALL come from pipeline_pkg.
REQ-021 Byte-lane logic (store byte-enable/data shift, load extract/extend) SHALL be sub-module dmem_lane_fmt, purely combinational; FSM and storage stay in dmem_responder.

Verification
REQ-022 SD 0x8877665544332211 to 0x010, then LD 0x010 -> rdata 0x8877665544332211, err 0; LB 0x017 -> 0xFFFFFFFFFFFFFF88; LBU 0x017 -> 0x88.
REQ-023 SH 0xBEEF to 0x012 over REQ-022 data, LD 0x010 -> 0x88776655BEEF2211; LH 0x012 -> 0xFFFFFFFFFFFFBEEF.
REQ-024 LATENCY=3, load accepted cycle N -> rsp_valid_o first high cycle N+4; rsp_ready_i low 5 cycles -> outputs stable, req_ready_o low throughout.
REQ-025 LW at 0x012: with DMEM_MISALIGN_CHECK_EN -> err 1, rdata 0; without -> data of 0x010, err 0; funct3=111 -> err 1 both builds.
REQ-026 rst_i in WAIT of SD 0x1 to 0x020 -> next cycle IDLE, rsp_valid_o 0; later LD 0x020 returns prior contents.
